// File: rtl/sram_arbiter.sv
// Two-port round-robin sequencer for an external asynchronous 8-bit SRAM.
// All pad-facing outputs come straight from flops; one access is in flight at a time.
module sram_arbiter #(
  parameter int AW      = 19,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [7:0]    wdata0,
  output logic          ack0,
  output logic [7:0]    rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    wdata1,
  output logic          ack1,
  output logic [7:0]    rdata1,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic [7:0]    sram_dout,
  output logic          sram_drive,
  input  logic [7:0]    sram_din,
  output logic          busy
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WSETUP  = 3'd2,
    WPULSE  = 3'd3,
    RECOVER = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sel_q;
  logic          last_grant_q;
  logic [AW-1:0] sram_addr_q;
  logic          sram_ce_n_q;
  logic          sram_we_n_q;
  logic          sram_oe_n_q;
  logic [7:0]    sram_dout_q;
  logic          sram_drive_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [7:0]    rdata0_q;
  logic [7:0]    rdata1_q;

  logic          grant_any_s;
  logic          grant_sel_s;
  logic          grant_we_s;
  logic [AW-1:0] grant_addr_s;
  logic [7:0]    grant_wdata_s;

  // Round-robin pick: on a tie the port that did not win last time is served.
  always_comb begin
    grant_any_s = req0 | req1;
    if (req0 && req1) begin
      grant_sel_s = ~last_grant_q;
    end else if (req1) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
    if (grant_sel_s) begin
      grant_we_s    = we1;
      grant_addr_s  = addr1;
      grant_wdata_s = wdata1;
    end else begin
      grant_we_s    = we0;
      grant_addr_s  = addr0;
      grant_wdata_s = wdata0;
    end
  end

  // Access sequencer; strobes, pad drive, acks and read data are all registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      sram_addr_q  <= '0;
      sram_ce_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_dout_q  <= 8'h00;
      sram_drive_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any_s) begin
            sel_q        <= grant_sel_s;
            last_grant_q <= grant_sel_s;
            sram_addr_q  <= grant_addr_s;
            sram_ce_n_q  <= 1'b0;
            sram_we_n_q  <= 1'b1;
            if (grant_we_s) begin
              sram_dout_q  <= grant_wdata_s;
              sram_drive_q <= 1'b1;
              sram_oe_n_q  <= 1'b1;
              state_q      <= WSETUP;
            end else begin
              sram_drive_q <= 1'b0;
              sram_oe_n_q  <= 1'b0;
              cnt_q        <= RD_LOAD;
              state_q      <= RD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (cnt_q == '0) begin
            if (sel_q) begin
              rdata1_q <= sram_din;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= sram_din;
              ack0_q   <= 1'b1;
            end
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            state_q     <= RECOVER;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WSETUP: begin
          sram_we_n_q <= 1'b0;
          cnt_q       <= WR_LOAD;
          state_q     <= WPULSE;
        end
        WPULSE: begin
          // Address, data, drive and CE stay put through the following hold cycle.
          if (cnt_q == '0) begin
            sram_we_n_q <= 1'b1;
            if (sel_q) begin
              ack1_q <= 1'b1;
            end else begin
              ack0_q <= 1'b1;
            end
            state_q <= RECOVER;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RECOVER: begin
          ack0_q       <= 1'b0;
          ack1_q       <= 1'b0;
          sram_ce_n_q  <= 1'b1;
          sram_we_n_q  <= 1'b1;
          sram_oe_n_q  <= 1'b1;
          sram_drive_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          ack0_q       <= 1'b0;
          ack1_q       <= 1'b0;
          sram_ce_n_q  <= 1'b1;
          sram_we_n_q  <= 1'b1;
          sram_oe_n_q  <= 1'b1;
          sram_drive_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_ce_n  = sram_ce_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_dout  = sram_dout_q;
  assign sram_drive = sram_drive_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: instance 0 uses 2/2 wait states, instance 1 uses 1/1.
// Each instance has a behavioural SRAM model; a monitor checks acks against queued expectations.
module tb_sram_arbiter;

  logic clk;
  logic reset_n;

  logic        req0_s   [2];
  logic        we0_s    [2];
  logic [18:0] addr0_s  [2];
  logic [7:0]  wdata0_s [2];
  logic        ack0_s   [2];
  logic [7:0]  rdata0_s [2];
  logic        req1_s   [2];
  logic        we1_s    [2];
  logic [18:0] addr1_s  [2];
  logic [7:0]  wdata1_s [2];
  logic        ack1_s   [2];
  logic [7:0]  rdata1_s [2];
  logic [18:0] addr_s   [2];
  logic        ce_n_s   [2];
  logic        we_n_s   [2];
  logic        oe_n_s   [2];
  logic [7:0]  dout_s   [2];
  logic        drive_s  [2];
  logic [7:0]  din_s    [2];
  logic        busy_s   [2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         d;
    int         p;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  sram_arbiter #(.AW(19), .RD_WAIT(2), .WR_WAIT(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0_s[0]), .we0(we0_s[0]), .addr0(addr0_s[0]), .wdata0(wdata0_s[0]),
    .ack0(ack0_s[0]), .rdata0(rdata0_s[0]),
    .req1(req1_s[0]), .we1(we1_s[0]), .addr1(addr1_s[0]), .wdata1(wdata1_s[0]),
    .ack1(ack1_s[0]), .rdata1(rdata1_s[0]),
    .sram_addr(addr_s[0]), .sram_ce_n(ce_n_s[0]), .sram_we_n(we_n_s[0]),
    .sram_oe_n(oe_n_s[0]), .sram_dout(dout_s[0]), .sram_drive(drive_s[0]),
    .sram_din(din_s[0]), .busy(busy_s[0])
  );

  sram_arbiter #(.AW(19), .RD_WAIT(1), .WR_WAIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0_s[1]), .we0(we0_s[1]), .addr0(addr0_s[1]), .wdata0(wdata0_s[1]),
    .ack0(ack0_s[1]), .rdata0(rdata0_s[1]),
    .req1(req1_s[1]), .we1(we1_s[1]), .addr1(addr1_s[1]), .wdata1(wdata1_s[1]),
    .ack1(ack1_s[1]), .rdata1(rdata1_s[1]),
    .sram_addr(addr_s[1]), .sram_ce_n(ce_n_s[1]), .sram_we_n(we_n_s[1]),
    .sram_oe_n(oe_n_s[1]), .sram_dout(dout_s[1]), .sram_drive(drive_s[1]),
    .sram_din(din_s[1]), .busy(busy_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int a);
    case (a)
      32'h01234: init_val = 8'hA5;
      32'h00010: init_val = 8'h11;
      32'h00020: init_val = 8'h22;
      default:   init_val = 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int d, input int p, input logic [7:0] rd);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ack: dut %0d port %0d acked with nothing expected (t=%0t)", d, p, $time);
    end else begin
      e = sb_q.pop_front();
      chk("ack_dut_port", d * 2 + p, e.d * 2 + e.p);
      chk("ack_cycle", cyc, e.cyc);
      if (e.rd) chk("rdata", int'(rd), int'(e.data));
    end
  endtask

  // SRAM model plus per-instance monitor (bus safety, turnaround gap, ack scoreboard).
  for (genvar g = 0; g < 2; g++) begin : g_sram
    logic [7:0] mem [int];
    logic p_ce = 1'b1;
    logic p_oe = 1'b1;
    logic p_dr = 1'b0;

    always @(negedge clk) begin
      if (!ce_n_s[g] && !we_n_s[g]) mem[int'(addr_s[g])] = dout_s[g];
      if (!ce_n_s[g] && !oe_n_s[g])
        din_s[g] <= mem.exists(int'(addr_s[g])) ? mem[int'(addr_s[g])] : init_val(int'(addr_s[g]));
      else
        din_s[g] <= 8'h00;
    end

    always @(negedge clk) begin
      chk("bus_conflict", int'(!oe_n_s[g] && drive_s[g]), 0);
      if (p_ce && !ce_n_s[g]) chk("turnaround_gap", int'(p_oe && !p_dr), 1);
      p_ce <= ce_n_s[g];
      p_oe <= oe_n_s[g];
      p_dr <= drive_s[g];
      if (ack0_s[g]) sb_pop(g, 0, rdata0_s[g]);
      if (ack1_s[g]) sb_pop(g, 1, rdata1_s[g]);
    end
  end

  task automatic set_req(input int d, input int p, input logic v, input logic we,
                         input logic [18:0] a, input logic [7:0] wd);
    if (p == 0) begin
      req0_s[d] = v; we0_s[d] = we; addr0_s[d] = a; wdata0_s[d] = wd;
    end else begin
      req1_s[d] = v; we1_s[d] = we; addr1_s[d] = a; wdata1_s[d] = wd;
    end
  endtask

  function automatic logic ack_of(input int d, input int p);
    ack_of = (p == 0) ? ack0_s[d] : ack1_s[d];
  endfunction

  task automatic push(input int d, input int p, input bit rd, input logic [7:0] data, input int c);
    exp_t e;
    e.d = d; e.p = p; e.rd = rd; e.data = data; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // One access on an idle instance, called at a falling edge; strobes checked cycle by cycle.
  task automatic single(input int d, input int p, input logic we, input logic [18:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    int  wt;
    int  lat;
    bit  got;
    wt  = (d == 0) ? 2 : 1;
    lat = we ? wt + 1 : wt;
    push(d, p, !we, exp_rd, cyc + 1 + lat);
    set_req(d, p, 1'b1, we, a, wd);
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      got = ack_of(d, p);
      if (!we) begin
        if (k <= wt) begin
          chk("rd_ce_n", ce_n_s[d], 0);
          chk("rd_oe_n", oe_n_s[d], 0);
          chk("rd_drive", drive_s[d], 0);
          chk("rd_addr", int'(addr_s[d]), int'(a));
        end else begin
          chk("rd_end_ce_n", ce_n_s[d], 1);
          chk("rd_end_oe_n", oe_n_s[d], 1);
          chk("rd_end_drive", drive_s[d], 0);
        end
      end else begin
        chk("wr_drive", drive_s[d], 1);
        chk("wr_ce_n", ce_n_s[d], 0);
        chk("wr_oe_n", oe_n_s[d], 1);
        chk("wr_addr", int'(addr_s[d]), int'(a));
        chk("wr_dout", int'(dout_s[d]), int'(wd));
        if (k == 1 || k > wt + 1) chk("wr_we_n_high", we_n_s[d], 1);
        else chk("wr_we_n_low", we_n_s[d], 0);
      end
    end
    chk("ack_seen", int'(got), 1);
    set_req(d, p, 1'b0, 1'b0, 19'h0, 8'h00);
    @(negedge clk);
    chk("post_ack", int'(ack_of(d, p)), 0);
    chk("post_ce_n", ce_n_s[d], 1);
    chk("post_oe_n", oe_n_s[d], 1);
    chk("post_drive", drive_s[d], 0);
    chk("post_busy", busy_s[d], 0);
  endtask

  // Hold the already-raised requests until n acks have been seen, then release both.
  task automatic burst(input int d, input int n);
    int seen = 0;
    for (int t = 0; t < 100 && seen < n; t++) begin
      @(negedge clk);
      if (ack0_s[d]) seen++;
      if (ack1_s[d]) seen++;
    end
    chk("burst_acks", seen, n);
    set_req(d, 0, 1'b0, 1'b0, 19'h0, 8'h00);
    set_req(d, 1, 1'b0, 1'b0, 19'h0, 8'h00);
    @(negedge clk);
    chk("burst_idle", busy_s[d], 0);
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b0, 1'b0, 19'h0, 8'h00);
      set_req(d, 1, 1'b0, 1'b0, 19'h0, 8'h00);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce_n", ce_n_s[d], 1);
      chk("rst_we_n", we_n_s[d], 1);
      chk("rst_oe_n", oe_n_s[d], 1);
      chk("rst_drive", drive_s[d], 0);
      chk("rst_addr", int'(addr_s[d]), 0);
      chk("rst_dout", int'(dout_s[d]), 0);
      chk("rst_acks", int'({ack0_s[d], ack1_s[d]}), 0);
      chk("rst_rdata", int'({rdata0_s[d], rdata1_s[d]}), 0);
      chk("rst_busy", busy_s[d], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Port 0 read, port 1 write then read back.
    single(0, 0, 1'b0, 19'h01234, 8'h00, 8'hA5);
    single(0, 1, 1'b1, 19'h7FFFF, 8'h3C, 8'h00);
    chk("model_wr", int'(g_sram[0].mem.exists(32'h7FFFF) ? g_sram[0].mem[32'h7FFFF] : 8'h00), 'h3C);
    chk("rdata1_hold", int'(rdata1_s[0]), 0);
    single(0, 1, 1'b0, 19'h7FFFF, 8'h00, 8'h3C);
    chk("rdata0_hold", int'(rdata0_s[0]), 'hA5);

    // Simultaneous requests straight out of reset: port 0 wins the tie.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    c = cyc;
    push(0, 0, 1'b1, 8'h11, c + 3);
    push(0, 1, 1'b1, 8'h22, c + 7);
    set_req(0, 0, 1'b1, 1'b0, 19'h00010, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 19'h00020, 8'h00);
    burst(0, 2);

    // Both held continuously: strict alternation every RD_WAIT+2 cycles.
    c = cyc;
    push(0, 0, 1'b1, 8'h11, c + 3);
    push(0, 1, 1'b1, 8'h22, c + 7);
    push(0, 0, 1'b1, 8'h11, c + 11);
    push(0, 1, 1'b1, 8'h22, c + 15);
    set_req(0, 0, 1'b1, 1'b0, 19'h00010, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 19'h00020, 8'h00);
    burst(0, 4);

    // Port 0 alone held: back-to-back reads spaced 4 cycles.
    c = cyc;
    push(0, 0, 1'b1, 8'hA5, c + 3);
    push(0, 0, 1'b1, 8'hA5, c + 7);
    push(0, 0, 1'b1, 8'hA5, c + 11);
    set_req(0, 0, 1'b1, 1'b0, 19'h01234, 8'h00);
    burst(0, 3);

    // Reset during the write pulse: strobes release immediately and no ack follows.
    set_req(0, 0, 1'b1, 1'b1, 19'h00100, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wpulse", we_n_s[0], 0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_we_n", we_n_s[0], 1);
    chk("abort_ce_n", ce_n_s[0], 1);
    chk("abort_oe_n", oe_n_s[0], 1);
    chk("abort_drive", drive_s[0], 0);
    chk("abort_busy", busy_s[0], 0);
    set_req(0, 0, 1'b0, 1'b0, 19'h0, 8'h00);
    @(negedge clk);
    chk("abort_no_ack", int'(ack0_s[0]), 0);
    reset_n = 1'b1;
    single(0, 0, 1'b0, 19'h01234, 8'h00, 8'hA5);

    // Minimum wait-state instance.
    single(1, 0, 1'b1, 19'h00055, 8'h77, 8'h00);
    single(1, 1, 1'b0, 19'h00055, 8'h00, 8'h77);
    single(1, 0, 1'b0, 19'h00010, 8'h00, 8'h11);
    c = cyc;
    push(1, 1, 1'b1, 8'h77, c + 2);
    push(1, 0, 1'b1, 8'h11, c + 5);
    set_req(1, 0, 1'b1, 1'b0, 19'h00010, 8'h00);
    set_req(1, 1, 1'b1, 1'b0, 19'h00055, 8'h00);
    burst(1, 2);

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
